// File: rtl/grid_renderer.sv
// grid_renderer: walks a GRID_W x GRID_H board and emits one pixel write per
// cycle. Each cell is drawn as a CELL x CELL square. After the cells, an
// optional cursor ring is drawn. In differential mode only cells that changed
// since the last completed frame are redrawn, plus the previous cursor cell.
//
// Ports
//   clock, resetn      single clock, synchronous active-low reset
//   startDraw          frame request, honoured only while idle
//   diff_mode          0 = full redraw, 1 = changed cells only (latched)
//   current_state      board, bit row*GRID_W+col, 1 = alive (latched)
//   cursor_enable      draw cursor ring this frame (latched)
//   x_cursor/y_cursor  cursor cell (latched)
//   x_vga/y_vga/color  pixel write, zero whenever writeEn is low
//   writeEn            pixel valid strobe
//   busy               frame in progress
//   finishDraw         one-cycle end-of-frame pulse
module grid_renderer #(
   parameter int          GRID_W       = 40,
   parameter int          GRID_H       = 30,
   parameter int          CELL         = 4,
   parameter int          X_W          = 8,
   parameter int          Y_W          = 7,
   parameter int          CX_W         = 6,
   parameter int          CY_W         = 5,
   parameter logic [2:0]  ALIVE_COLOR  = 3'b111,
   parameter logic [2:0]  DEAD_COLOR   = 3'b000,
   parameter logic [2:0]  CURSOR_COLOR = 3'b011
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     startDraw,
   input  logic                     diff_mode,
   input  logic [GRID_W*GRID_H-1:0] current_state,
   input  logic                     cursor_enable,
   input  logic [CX_W-1:0]          x_cursor,
   input  logic [CY_W-1:0]          y_cursor,
   output logic [X_W-1:0]           x_vga,
   output logic [Y_W-1:0]           y_vga,
   output logic [2:0]               color,
   output logic                     writeEn,
   output logic                     busy,
   output logic                     finishDraw
);

   localparam int N     = GRID_W * GRID_H;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = $clog2(CELL);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_PIXEL, S_CURSOR, S_DONE} state_t;
   state_t state, state_next, scan_exit;

   logic [N-1:0]     snap, shadow;
   logic             shadow_valid, prev_cur_valid;
   logic             lat_diff, lat_cen;
   logic [CX_W-1:0]  lat_cx, prev_cx, col;
   logic [CY_W-1:0]  lat_cy, prev_cy, row;
   logic [IDX_W-1:0] idx;
   logic [PW-1:0]    px, py;

   logic             last_cell, cell_need, ring_ok, px_last, py_last, edge_row;
   logic [X_W-1:0]   o_x;
   logic [Y_W-1:0]   o_y;
   logic [2:0]       o_color;
   logic             o_we, o_busy, o_fin;

   always_ff @(posedge clock) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_we       = 1'b0;
      o_x        = '0;
      o_y        = '0;
      o_color    = '0;
      o_fin      = 1'b0;
      o_busy     = (state != S_IDLE);
      last_cell  = (idx == IDX_W'(N - 1));
      px_last    = (px == PW'(CELL - 1));
      py_last    = (py == PW'(CELL - 1));
      edge_row   = (py == '0) || py_last;
      // Old cursor cell is redrawn so its ring gets erased.
      cell_need  = !lat_diff || !shadow_valid || (snap[idx] != shadow[idx]) ||
                   (prev_cur_valid && (col == prev_cx) && (row == prev_cy));
      ring_ok    = lat_cen && (32'(lat_cx) < GRID_W) && (32'(lat_cy) < GRID_H);
      scan_exit  = ring_ok ? S_CURSOR : S_DONE;
      case (state)
         S_IDLE:  if (startDraw) state_next = S_LOAD;
         S_LOAD:  state_next = S_SCAN;
         S_SCAN: begin
            if (cell_need)      state_next = S_PIXEL;
            else if (last_cell) state_next = scan_exit;
         end
         S_PIXEL: begin
            o_we    = 1'b1;
            o_x     = X_W'(col) * X_W'(CELL) + X_W'(px);
            o_y     = Y_W'(row) * Y_W'(CELL) + Y_W'(py);
            o_color = snap[idx] ? ALIVE_COLOR : DEAD_COLOR;
            if (px_last && py_last) state_next = last_cell ? scan_exit : S_SCAN;
         end
         S_CURSOR: begin
            o_we    = 1'b1;
            o_x     = X_W'(lat_cx) * X_W'(CELL) + X_W'(px);
            o_y     = Y_W'(lat_cy) * Y_W'(CELL) + Y_W'(py);
            o_color = CURSOR_COLOR;
            if (px_last && py_last) state_next = S_DONE;
         end
         S_DONE: begin
            o_fin      = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         snap           <= '0;
         shadow         <= '0;
         shadow_valid   <= 1'b0;
         prev_cur_valid <= 1'b0;
         prev_cx        <= '0;
         prev_cy        <= '0;
         lat_diff       <= 1'b0;
         lat_cen        <= 1'b0;
         lat_cx         <= '0;
         lat_cy         <= '0;
         idx            <= '0;
         col            <= '0;
         row            <= '0;
         px             <= '0;
         py             <= '0;
         x_vga          <= '0;
         y_vga          <= '0;
         color          <= '0;
         writeEn        <= 1'b0;
         busy           <= 1'b0;
         finishDraw     <= 1'b0;
      end else begin
         x_vga      <= o_x;
         y_vga      <= o_y;
         color      <= o_color;
         writeEn    <= o_we;
         busy       <= o_busy;
         finishDraw <= o_fin;
         case (state)
            S_LOAD: begin
               snap     <= current_state;
               lat_diff <= diff_mode;
               lat_cen  <= cursor_enable;
               lat_cx   <= x_cursor;
               lat_cy   <= y_cursor;
               idx      <= '0;
               col      <= '0;
               row      <= '0;
               px       <= '0;
               py       <= '0;
            end
            S_SCAN: begin
               if (!cell_need && !last_cell) begin
                  idx <= idx + IDX_W'(1);
                  if (col == CX_W'(GRID_W - 1)) begin
                     col <= '0;
                     row <= row + CY_W'(1);
                  end else begin
                     col <= col + CX_W'(1);
                  end
               end
            end
            S_PIXEL: begin
               if (px_last) begin
                  px <= '0;
                  if (py_last) begin
                     py <= '0;
                     if (!last_cell) begin
                        idx <= idx + IDX_W'(1);
                        if (col == CX_W'(GRID_W - 1)) begin
                           col <= '0;
                           row <= row + CY_W'(1);
                        end else begin
                           col <= col + CX_W'(1);
                        end
                     end
                  end else begin
                     py <= py + PW'(1);
                  end
               end else begin
                  px <= px + PW'(1);
               end
            end
            S_CURSOR: begin
               // Top/bottom rows walk every column; middle rows hop between
               // the left and right edge columns only.
               if (edge_row) begin
                  if (px_last) begin
                     px <= '0;
                     py <= py_last ? '0 : py + PW'(1);
                  end else begin
                     px <= px + PW'(1);
                  end
               end else if (px == '0) begin
                  px <= PW'(CELL - 1);
               end else begin
                  px <= '0;
                  py <= py + PW'(1);
               end
            end
            S_DONE: begin
               shadow         <= snap;
               shadow_valid   <= 1'b1;
               prev_cur_valid <= ring_ok;
               if (ring_ok) begin
                  prev_cx <= lat_cx;
                  prev_cy <= lat_cy;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_renderer.sv
// Bench for grid_renderer: a default-size instance (a_*) and an 8x6, CELL=3
// instance (b_*). The reference model lists the expected pixel writes of a
// frame directly from the drawing rules.
module tb_grid_renderer;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic resetn;

   logic          a_start, a_diff, a_cen;
   logic [1199:0] a_board;
   logic [5:0]    a_cx;
   logic [4:0]    a_cy;
   logic [7:0]    a_x;
   logic [6:0]    a_y;
   logic [2:0]    a_col;
   logic          a_we, a_busy, a_fin;

   logic          b_start, b_diff, b_cen;
   logic [47:0]   b_board;
   logic [3:0]    b_cx;
   logic [2:0]    b_cy;
   logic [4:0]    b_x, b_y;
   logic [2:0]    b_col;
   logic          b_we, b_busy, b_fin;

   grid_renderer dut_a (
      .clock(clock), .resetn(resetn), .startDraw(a_start), .diff_mode(a_diff),
      .current_state(a_board), .cursor_enable(a_cen), .x_cursor(a_cx), .y_cursor(a_cy),
      .x_vga(a_x), .y_vga(a_y), .color(a_col), .writeEn(a_we), .busy(a_busy),
      .finishDraw(a_fin));

   grid_renderer #(.GRID_W(8), .GRID_H(6), .CELL(3), .X_W(5), .Y_W(5), .CX_W(4), .CY_W(3)) dut_b (
      .clock(clock), .resetn(resetn), .startDraw(b_start), .diff_mode(b_diff),
      .current_state(b_board), .cursor_enable(b_cen), .x_cursor(b_cx), .y_cursor(b_cy),
      .x_vga(b_x), .y_vga(b_y), .color(b_col), .writeEn(b_we), .busy(b_busy),
      .finishDraw(b_fin));

   int checks = 0;
   int failures = 0;
   int qa[$];
   int qb[$];
   logic [1199:0] m_shadow [2];
   bit  m_sv [2];
   bit  m_pv [2];
   int  m_pcx [2];
   int  m_pcy [2];
   int  exp_len;
   int  fin_c;
   int  wr_cnt [2];
   int  col_cnt [2][8];
   int  last_x [2];
   int  last_y [2];
   int  rf_x [2];
   int  rf_y [2];
   int  rl_x [2];
   int  rl_y [2];
   bit  rf_seen [2];
   bit  cmp_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic clear_stats(input int sel);
      wr_cnt[sel] = 0;
      for (int i = 0; i < 8; i++) col_cnt[sel][i] = 0;
      last_x[sel] = -1; last_y[sel] = -1;
      rf_x[sel] = -1; rf_y[sel] = -1; rl_x[sel] = -1; rl_y[sel] = -1;
      rf_seen[sel] = 1'b0;
   endtask

   // Expected writes of one frame, straight from the drawing rules.
   task automatic model(input int sel, input logic [1199:0] board, input logic diff,
                        input logic cen, input int cx, input int cy);
      int gw, gh, cl, i, pk;
      bit need, ring;
      gw = (sel == 0) ? 40 : 8;
      gh = (sel == 0) ? 30 : 6;
      cl = (sel == 0) ? 4 : 3;
      exp_len = 2;
      for (int r = 0; r < gh; r++) begin
         for (int c = 0; c < gw; c++) begin
            i = r * gw + c;
            need = !diff || !m_sv[sel] || (board[i] != m_shadow[sel][i]) ||
                   (m_pv[sel] && c == m_pcx[sel] && r == m_pcy[sel]);
            exp_len += 1;
            if (need) begin
               exp_len += cl * cl;
               for (int yy = 0; yy < cl; yy++)
                  for (int xx = 0; xx < cl; xx++) begin
                     pk = ((c * cl + xx) << 16) | ((r * cl + yy) << 4) | (board[i] ? 7 : 0);
                     if (sel == 0) qa.push_back(pk); else qb.push_back(pk);
                  end
            end
         end
      end
      ring = cen && cx < gw && cy < gh;
      if (ring) begin
         exp_len += 4 * cl - 4;
         for (int yy = 0; yy < cl; yy++)
            for (int xx = 0; xx < cl; xx++)
               if (yy == 0 || yy == cl - 1 || xx == 0 || xx == cl - 1) begin
                  pk = ((cx * cl + xx) << 16) | ((cy * cl + yy) << 4) | 3;
                  if (sel == 0) qa.push_back(pk); else qb.push_back(pk);
               end
      end
      m_shadow[sel] = board;
      m_sv[sel] = 1'b1;
      m_pv[sel] = ring;
      m_pcx[sel] = cx;
      m_pcy[sel] = cy;
   endtask

   task automatic observe(input int sel, input logic we, input int x, input int y, input int c);
      int pk, e;
      pk = (x << 16) | (y << 4) | c;
      if (we) begin
         wr_cnt[sel]++;
         col_cnt[sel][c]++;
         last_x[sel] = x; last_y[sel] = y;
         if (c == 3) begin
            if (!rf_seen[sel]) begin rf_seen[sel] = 1'b1; rf_x[sel] = x; rf_y[sel] = y; end
            rl_x[sel] = x; rl_y[sel] = y;
         end
         if ((sel == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write dut=%0d x=%0d y=%0d color=%0d expected=no write", sel, x, y, c);
         end else begin
            e = (sel == 0) ? qa.pop_front() : qb.pop_front();
            check((sel == 0) ? "pixel_a" : "pixel_b", pk, e);
         end
      end else begin
         check((sel == 0) ? "idle_zero_a" : "idle_zero_b", pk, 0);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_on) begin
         observe(0, a_we, int'(a_x), int'(a_y), int'(a_col));
         observe(1, b_we, int'(b_x), int'(b_y), int'(b_col));
      end
   end

   task automatic drive(input int sel, input logic [1199:0] board, input logic diff,
                        input logic cen, input int cx, input int cy, input logic st);
      if (sel == 0) begin
         a_board = board; a_diff = diff; a_cen = cen; a_cx = 6'(cx); a_cy = 5'(cy); a_start = st;
      end else begin
         b_board = board[47:0]; b_diff = diff; b_cen = cen; b_cx = 4'(cx); b_cy = 3'(cy); b_start = st;
      end
   endtask

   task automatic set_start(input int sel, input logic st);
      if (sel == 0) a_start = st; else b_start = st;
   endtask

   function automatic logic [1199:0] rand_board();
      logic [1199:0] r;
      for (int i = 0; i < 1200; i++) r[i] = 1'($urandom);
      return r;
   endfunction

   task automatic run_frame(input int sel, input logic [1199:0] board, input logic diff,
                            input logic cen, input int cx, input int cy, input bit pulse);
      logic bz, fn;
      model(sel, board, diff, cen, cx, cy);
      clear_stats(sel);
      @(negedge clock); #1;
      drive(sel, board, diff, cen, cx, cy, 1'b1);
      @(posedge clock); #1;
      set_start(sel, 1'b0);
      fin_c = -1;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clock); #1;
         bz = (sel == 0) ? a_busy : b_busy;
         fn = (sel == 0) ? a_fin : b_fin;
         if (c == 0) check("busy_before_load", int'(bz), 0);
         if (c == 1) check("busy_rise", int'(bz), 1);
         // Inputs move mid-frame; the latched snapshot must be used.
         if (c == 2) drive(sel, rand_board(), !diff, !cen, cx + 1, cy + 1, 1'b0);
         set_start(sel, pulse && (c == 5 || c == 20));
         if (fn) begin fin_c = c; break; end
      end
      set_start(sel, 1'b0);
      check("frame_len", fin_c, exp_len);
      @(negedge clock); #1;
      check("busy_fall", int'((sel == 0) ? a_busy : b_busy), 0);
      check("finish_single", int'((sel == 0) ? a_fin : b_fin), 0);
      check("queue_drained", (sel == 0) ? qa.size() : qb.size(), 0);
      if (pulse) begin
         repeat (3) begin
            @(negedge clock); #1;
            check("no_retrigger", int'((sel == 0) ? a_busy : b_busy), 0);
         end
      end
   endtask

   initial begin
      logic [1199:0] brd;
      int n;
      resetn = 1'b0;
      drive(0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
      drive(1, '0, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         m_shadow[s] = '0; m_sv[s] = 1'b0; m_pv[s] = 1'b0; m_pcx[s] = 0; m_pcy[s] = 0;
         clear_stats(s);
      end
      repeat (3) @(negedge clock);
      #1;
      check("rst_a_we", int'(a_we), 0);
      check("rst_a_busy", int'(a_busy), 0);
      check("rst_a_fin", int'(a_fin), 0);
      check("rst_a_xyc", int'({a_x, a_y, a_col}), 0);
      check("rst_b_we", int'(b_we), 0);
      check("rst_b_busy", int'(b_busy), 0);
      check("rst_b_fin", int'(b_fin), 0);
      check("rst_b_xyc", int'({b_x, b_y, b_col}), 0);
      resetn = 1'b1;
      cmp_on = 1'b1;

      // All-zero board, full redraw, no cursor.
      brd = '0;
      run_frame(0, brd, 1'b0, 1'b0, 0, 0, 1'b0);
      check("t1_writes", wr_cnt[0], 19200);
      check("t1_black", col_cnt[0][0], 19200);
      check("t1_len", fin_c, 20402);
      check("t1_last_x", last_x[0], 159);
      check("t1_last_y", last_y[0], 119);

      // Single live cell (row 1, col 1) with cursor at (0,0).
      brd[41] = 1'b1;
      run_frame(0, brd, 1'b0, 1'b1, 0, 0, 1'b0);
      check("t2_alive", col_cnt[0][7], 16);
      check("t2_ring", col_cnt[0][3], 12);
      check("t2_ring_first", rf_x[0] * 1000 + rf_y[0], 0);
      check("t2_ring_last", rl_x[0] * 1000 + rl_y[0], 3003);
      check("t2_len", fin_c, 20414);

      // Diff mode, board unchanged, cursor moved to (2,0).
      run_frame(0, brd, 1'b1, 1'b1, 2, 0, 1'b0);
      check("t3_writes", wr_cnt[0], 28);
      check("t3_erase", col_cnt[0][0], 16);
      check("t3_ring_first_x", rf_x[0], 8);
      check("t3_ring_last", rl_x[0] * 1000 + rl_y[0], 11003);

      // Diff mode, cell 41 cleared, cursor off.
      brd[41] = 1'b0;
      run_frame(0, brd, 1'b1, 1'b0, 0, 0, 1'b0);
      check("t4_writes", wr_cnt[0], 32);
      check("t4_black", col_cnt[0][0], 32);
      check("t4_len", fin_c, 1234);

      // No change and no previous ring: nothing is drawn.
      run_frame(0, brd, 1'b1, 1'b0, 0, 0, 1'b0);
      check("t5_writes", wr_cnt[0], 0);
      check("t5_len", fin_c, 1202);

      // Sparse random changes on the default board.
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
         int b;
         b = $urandom_range(0, 1199);
         brd[b] = !brd[b];
      end
      run_frame(0, brd, 1'b1, 1'b1, $urandom_range(0, 63), $urandom_range(0, 31), 1'b0);

      // Small grid: checkerboard, out-of-range cursor, startDraw pulsed while busy.
      brd = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 8; c++) brd[r * 8 + c] = 1'((r + c) % 2);
      run_frame(1, brd, 1'b0, 1'b1, 9, 2, 1'b1);
      check("sw_writes", wr_cnt[1], 432);
      check("sw_alive", col_cnt[1][7], 216);
      check("sw_no_ring", col_cnt[1][3], 0);
      check("sw_len", fin_c, 482);

      // Random frames on the small grid.
      for (int it = 0; it < 10; it++) begin
         n = $urandom_range(0, 5);
         for (int k = 0; k < n; k++) begin
            int b;
            b = $urandom_range(0, 47);
            brd[b] = !brd[b];
         end
         run_frame(1, brd, 1'($urandom), 1'($urandom), $urandom_range(0, 15),
                   $urandom_range(0, 7), bit'($urandom));
      end

      // Reset while drawing the first cell.
      brd = rand_board();
      model(0, brd, 1'b0, 1'b0, 0, 0);
      clear_stats(0);
      @(negedge clock); #1;
      drive(0, brd, 1'b0, 1'b0, 0, 0, 1'b1);
      @(posedge clock); #1;
      a_start = 1'b0;
      repeat (10) @(negedge clock);
      #1;
      check("mid_pixel_we", int'(a_we), 1);
      resetn = 1'b0;
      @(negedge clock); #1;
      check("abort_we", int'(a_we), 0);
      check("abort_busy", int'(a_busy), 0);
      qa.delete();
      qb.delete();
      for (int s = 0; s < 2; s++) begin m_sv[s] = 1'b0; m_pv[s] = 1'b0; end
      resetn = 1'b1;
      run_frame(0, rand_board(), 1'b1, 1'b0, 0, 0, 1'b0);
      check("post_rst_a_writes", wr_cnt[0], 19200);
      run_frame(1, rand_board(), 1'b1, 1'b0, 0, 0, 1'b0);
      check("post_rst_b_writes", wr_cnt[1], 432);

      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grid_renderer.md
# grid_renderer

Parametrised framebuffer renderer for the Game of Life board. Walks a GRID_W x GRID_H cell vector and emits one VGA pixel write per cycle. Each cell is drawn as a CELL x CELL square, followed by an optional cursor ring. A differential mode redraws only cells that changed since the last completed frame, which cuts redraw time for sparse boards. It sits between the life-update core and the VGA adapter and replaces the fixed 40x30, 4-pixel drawing path.

## Interface
- GRID_W, 40, board columns
- GRID_H, 30, board rows
- CELL, 4, cell edge in pixels; must be >= 2
- X_W, 8, pixel x width; GRID_W*CELL-1 must fit
- Y_W, 7, pixel y width; GRID_H*CELL-1 must fit
- CX_W, 6, cursor column width; must hold GRID_W-1
- CY_W, 5, cursor row width; must hold GRID_H-1
- ALIVE_COLOR, 3'b111; DEAD_COLOR, 3'b000; CURSOR_COLOR, 3'b011
- clock  in  1  single clock; every register changes on its rising edge
- resetn  in  1  synchronous, active-low reset
- startDraw  in  1  frame request; sampled only in IDLE
- diff_mode  in  1  0 = full redraw, 1 = redraw changed cells only; latched at start
- current_state  in  GRID_W*GRID_H  board; bit index = row*GRID_W + col; 1 = alive
- cursor_enable  in  1  draw the cursor ring this frame; latched at start
- x_cursor  in  CX_W  cursor column; latched at start
- y_cursor  in  CY_W  cursor row; latched at start
- x_vga  out  X_W  pixel x
- y_vga  out  Y_W  pixel y
- color  out  3  pixel colour
- writeEn  out  1  pixel valid strobe
- busy  out  1  high from LOAD through DONE
- finishDraw  out  1  one-cycle pulse in DONE

## Operation
- The FSM has six states: IDLE, LOAD, SCAN, PIXEL, CURSOR, DONE.
- **IDLE**
  - Goes to LOAD when startDraw=1.
  - startDraw is ignored in every other state; there is no queuing.
- **LOAD** (1 cycle)
  - Latches a snapshot of current_state, diff_mode, cursor_enable, x_cursor and y_cursor.
  - Clears the cell index. Later changes on these inputs do not affect the frame in progress.
- **SCAN** (1 cycle per cell, no write)
  - Cell i needs drawing if any of these holds:
    - the latched diff_mode=0;
    - shadow_valid=0;
    - snap[i] != shadow[i];
    - i is the previously drawn cursor cell (prev_cur_valid=1), so the old ring is erased.
  - If the cell needs drawing, go to PIXEL. Otherwise go to the next cell, or to CURSOR/DONE after the last cell.
- **PIXEL** (CELL*CELL cycles)
  - Writes the square row-major, starting at (col*CELL, row*CELL).
  - Colour is ALIVE_COLOR when snap[i]=1, else DEAD_COLOR.
  - After the last pixel: return to SCAN for i+1, or leave the scan if i = GRID_W*GRID_H-1.
- **Leaving the scan**
  - Go to CURSOR if the latched cursor_enable=1, x_cursor<GRID_W and y_cursor<GRID_H.
  - Otherwise go to DONE.
- **CURSOR** (4*CELL-4 cycles)
  - Writes the perimeter of the cursor cell in CURSOR_COLOR.
  - Order: top row left to right, then the left and right pixels of each middle row top to bottom, then the bottom row left to right.
- **DONE** (1 cycle)
  - finishDraw=1.
  - shadow <= snap; shadow_valid <= 1.
  - If a ring was drawn: prev_cur <= latched cursor and prev_cur_valid <= 1. Otherwise prev_cur_valid <= 0.
  - Then go to IDLE.
- **Arithmetic**
  - Pixel coordinates are computed at X_W/Y_W width. The parameter constraints guarantee no overflow.
  - Cell index counter is clog2(GRID_W*GRID_H) wide and stops at the last cell; it does not wrap.

## Timing
- **Reset**
  - State IDLE.
  - x_vga, y_vga, color, writeEn, busy, finishDraw all 0.
  - shadow_valid=0, prev_cur_valid=0, snapshot cleared.
  - Reset mid-frame aborts immediately; the next frame is a full redraw.
- **Outputs**
  - All outputs are registered.
  - writeEn=1 in exactly the PIXEL and CURSOR cycles.
  - When writeEn=0, x_vga=0, y_vga=0, color=0.
- **Latency**
  - startDraw at edge k puts LOAD in cycle k+1. The first SCAN is at k+2 and the first pixel at k+3.
- **Frame length (full mode)**
  - 1 (LOAD) + N*(1+CELL²) + R + 1 (DONE), where N = GRID_W*GRID_H and R = 4*CELL-4 if the ring is drawn, else 0.
  - Defaults with cursor: 20414 cycles.
- **Frame length (diff mode)**
  - Same as full mode, but each skipped cell costs 1 cycle instead of 1+CELL².
- **busy**
  - Rises the cycle after startDraw and falls the cycle after finishDraw.
  - startDraw asserted while busy is dropped.
  - startDraw held high re-triggers from IDLE, giving back-to-back frames separated by one IDLE cycle.

## Test plan
- **Reset then full frame, defaults, all-zero board, cursor off:** writeEn high for exactly 19200 cycles, all with color=000; finishDraw is a single pulse at cycle 20402 after start; the last pixel is (159,119).
- **Full frame, only bit 41 set (row 1, col 1), cursor at (0,0):** pixels x 4..7, y 4..7 have color 111; then a 12-pixel ring with color 011 whose first pixel is (0,0) and last is (3,3).
- **Diff mode after that frame, board unchanged, cursor moved to (2,0):** only cell 0 (old cursor) is redrawn (16 writes, 000), then the ring at x=8..11; 28 writes total.
- **Diff mode, bit 41 cleared, cursor off:** writes only cell 41 (16 pixels, 000) plus cell 2 (old cursor erase); prev_cur_valid=0 afterwards.
- **Parameter sweep GRID_W=8, GRID_H=6, CELL=3 (X_W=5, Y_W=5):**
  - checkerboard board gives 432 writes, each with the correct colour;
  - out-of-range cursor x=9 means no ring is drawn;
  - pulsing startDraw while busy changes nothing.
- **Reset asserted mid-PIXEL:** the next cycle has writeEn=0, busy=0; the next diff-mode frame redraws all cells.
